// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter (rr_arbiter8).
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] onehot8(input logic [ID_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Client/arbiter handshake bundle: request lines in, registered grant info out.
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             timeout;

  modport master (output req, input gnt, input gnt_id, input busy, input timeout);
  modport slave  (input req, output gnt, output gnt_id, output busy, output timeout);

endinterface

// File: rtl/Or8Way.sv
// 8-input OR gate used for the arbiter's request-detect.
module Or8Way (
  input  logic [7:0] in,
  output logic       out
);

  assign out = |in;

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, mod 8.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  enc;

  always_comb begin
    // Rotate so ptr lands on bit 0, priority-encode, then undo the rotation.
    rot = N_REQ'({req, req} >> ptr);
    enc = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rot[i-1]) enc = ID_W'(i - 1);
    end
    idx   = enc + ptr;
    found = |rot;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter; owner holds until it drops req.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter8_if.slave  bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256 || (1 << CNT_W) < MAX_HOLD) begin : g_bad_cfg
    $error("rr_arbiter8: illegal MAX_HOLD/CNT_W combination");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             timeout_q, timeout_d;
  logic             any_req;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_q, hold_d;
`endif

  Or8Way u_any (
    .in  (bus.req),
    .out (any_req)
  );

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (any_req && pick_found) begin
          state_d = ARB_GRANT;
          gnt_d   = onehot8(pick_idx);
          id_d    = pick_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (!bus.req[id_q]) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          ptr_d   = id_q + 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          state_d   = ARB_IDLE;
          gnt_d     = '0;
          ptr_d     = id_q + 1'b1;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 (covers ARB_TIMEOUT_EN when defined).
module tb_rr_arbiter8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = 8'hFF;
    rst_n   = 1'b0;
    repeat (2) tick();
    n_vec++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt: got %h want 00", bus.gnt); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.gnt_id !== 3'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", bus.gnt_id); end
    n_vec++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (bus.gnt !== 8'h01) begin n_err++; $display("FAIL reset_first_gnt: got %h want 01", bus.gnt); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL reset_first_busy: got %b want 1", bus.busy); end
    bus.req = 8'h00;
    tick();
    n_vec++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL reset_release: got %h want 00", bus.gnt); end
  endtask

  task automatic test_single();
    bus.req = 8'b0001_0000;
    tick();
    n_vec++; if (bus.gnt !== 8'h10) begin n_err++; $display("FAIL single_gnt: got %h want 10", bus.gnt); end
    n_vec++; if (bus.gnt_id !== 3'd4) begin n_err++; $display("FAIL single_id: got %0d want 4", bus.gnt_id); end
    bus.req = 8'b0001_0011;
    tick();
    n_vec++; if (bus.gnt !== 8'h10) begin n_err++; $display("FAIL single_hold: got %h want 10", bus.gnt); end
    bus.req = 8'h00;
    tick();
    n_vec++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL single_drop: got %h want 00", bus.gnt); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_rotation();
    logic [2:0] id;
    logic [7:0] exp;
    reset_pulse();
    bus.req = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      id  = 3'(k);
      exp = 8'h01 << id;
      tick();
      n_vec++; if (bus.gnt !== exp) begin n_err++; $display("FAIL rot_gnt k=%0d: got %h want %h", k, bus.gnt, exp); end
      n_vec++; if (bus.gnt_id !== id) begin n_err++; $display("FAIL rot_id k=%0d: got %0d want %0d", k, bus.gnt_id, id); end
      tick();
      n_vec++; if (bus.gnt !== exp) begin n_err++; $display("FAIL rot_hold k=%0d: got %h want %h", k, bus.gnt, exp); end
      n_vec++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL rot_timeout k=%0d: got %b want 0", k, bus.timeout); end
      bus.req = 8'hFF & ~exp;
      tick();
      n_vec++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL rot_gap k=%0d: got %h want 00", k, bus.gnt); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rot_gap_busy k=%0d: got %b want 0", k, bus.busy); end
      bus.req = 8'hFF;
    end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_wrap();
    bus.req = 8'h40;
    tick();
    n_vec++; if (bus.gnt !== 8'h40) begin n_err++; $display("FAIL wrap_setup: got %h want 40", bus.gnt); end
    bus.req = 8'h00;
    tick();
    bus.req = 8'b0010_0001;
    tick();
    n_vec++; if (bus.gnt !== 8'h01) begin n_err++; $display("FAIL wrap_first: got %h want 01", bus.gnt); end
    n_vec++; if (bus.gnt_id !== 3'd0) begin n_err++; $display("FAIL wrap_first_id: got %0d want 0", bus.gnt_id); end
    bus.req = 8'b0010_0000;
    tick();
    n_vec++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL wrap_gap: got %h want 00", bus.gnt); end
    tick();
    n_vec++; if (bus.gnt !== 8'h20) begin n_err++; $display("FAIL wrap_second: got %h want 20", bus.gnt); end
    n_vec++; if (bus.gnt_id !== 3'd5) begin n_err++; $display("FAIL wrap_second_id: got %0d want 5", bus.gnt_id); end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_async_reset();
    bus.req = 8'h08;
    tick();
    n_vec++; if (bus.gnt !== 8'h08) begin n_err++; $display("FAIL arst_setup: got %h want 08", bus.gnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL arst_immediate: got %h want 00", bus.gnt); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
    bus.req = 8'h88;
    #2;
    rst_n = 1'b1;
    tick();
    n_vec++; if (bus.gnt !== 8'h08) begin n_err++; $display("FAIL arst_restart: got %h want 08", bus.gnt); end
    n_vec++; if (bus.gnt_id !== 3'd3) begin n_err++; $display("FAIL arst_restart_id: got %0d want 3", bus.gnt_id); end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_timeout();
    reset_pulse();
    bus.req = 8'h0C;
    tick();
    n_vec++; if (bus.gnt !== 8'h04) begin n_err++; $display("FAIL to_grant: got %h want 04", bus.gnt); end
`ifdef ARB_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_vec++; if (bus.gnt !== 8'h04) begin n_err++; $display("FAIL to_hold c=%0d: got %h want 04", c, bus.gnt); end
    end
    tick();
    n_vec++; if (bus.gnt !== 8'h00) begin n_err++; $display("FAIL to_release: got %h want 00", bus.gnt); end
    n_vec++; if (bus.timeout !== 1'b1) begin n_err++; $display("FAIL to_pulse: got %b want 1", bus.timeout); end
    tick();
    n_vec++; if (bus.gnt !== 8'h08) begin n_err++; $display("FAIL to_next: got %h want 08", bus.gnt); end
    n_vec++; if (bus.timeout !== 1'b0) begin n_err++; $display("FAIL to_pulse_end: got %b want 0", bus.timeout); end
`else
    for (int c = 2; c <= 21; c++) begin
      tick();
      n_vec++; if (bus.gnt !== 8'h04 || bus.timeout !== 1'b0) begin
        n_err++; $display("FAIL nto_hold c=%0d: got gnt %h to %b want 04/0", c, bus.gnt, bus.timeout);
      end
    end
`endif
    bus.req = 8'h00;
    tick();
  endtask

  initial begin
    bus.req = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_async_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
